dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder_array.sv | 27 ++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word size, FSM state
// encodings, operation codes and the latched request record.
// Imported by the interface, the storage array and the responder top.
package dmem_responder_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_BITS  = 16;
    localparam int WAIT_BITS = 4;   // holds LATENCY-1 for LATENCY up to 15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Request as captured at acceptance; it governs the whole access.
    typedef struct packed {
        op_t                  op;
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU <-> data-memory bus: level-held request, one-cycle response pulse, status.
// Ports: mem_read/mem_write/mem_addr/mem_wdata (CPU -> memory);
//        rsp_ready/rsp_rdata/busy/proto_err/rd_count/wr_count (memory -> CPU).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 busy;
    logic                 proto_err;
    logic [CNT_BITS-1:0]  rd_count;
    logic [CNT_BITS-1:0]  wr_count;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  rsp_ready, rsp_rdata, busy, proto_err, rd_count, wr_count
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output rsp_ready, rsp_rdata, busy, proto_err, rd_count, wr_count
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: 2^ADDR_BITS words, synchronous write port, combinational read.
// Latency: write lands at the clock edge, read data follows i_raddr combinationally.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read). Not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [WORD_SIZE-1:0] i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [WORD_SIZE-1:0] o_rdata
);

    logic [WORD_SIZE-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE -> LATENCY x WAIT -> RESP -> IDLE.
// Latency: rsp_ready is high LATENCY+1 cycles after the request is sampled in IDLE.
// Backpressure: requests are only sampled in IDLE; the CPU holds them until rsp_ready.
// Ports: clk, reset_n (synchronous, active-low), bus (slave side of dmem_responder_if).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY   = 4,   // 1..15
    parameter int ADDR_BITS = 8    // 1..16
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);

    localparam logic [WAIT_BITS-1:0] WAIT_LOAD = WAIT_BITS'(LATENCY - 1);

    state_t               r_state;
    req_t                 r_req;
    logic [WAIT_BITS-1:0] r_wait_cnt;
    logic                 r_rsp_ready;
    logic [WORD_SIZE-1:0] r_rsp_rdata;
    logic                 r_busy;
    logic                 r_proto_err;
    logic [CNT_BITS-1:0]  r_rd_count;
    logic [CNT_BITS-1:0]  r_wr_count;

    logic                 w_req_rd;
    logic                 w_req_wr;
    logic                 w_req_both;
    logic                 w_mem_we;
    logic [ADDR_BITS-1:0] w_addr;
    logic [WORD_SIZE-1:0] w_mem_rdata;

    assign w_req_rd   = bus.mem_read  & ~bus.mem_write;
    assign w_req_wr   = bus.mem_write & ~bus.mem_read;
    assign w_req_both = bus.mem_read  &  bus.mem_write;

    // Upper address bits are dropped, so addresses wrap silently.
    assign w_addr = r_req.addr[ADDR_BITS-1:0];

    // The write commits at the edge leaving RESP; a reset on that same edge
    // aborts the access, so reset_n gates the enable.
    assign w_mem_we = (r_state == ST_RESP) && (r_req.op == OP_WRITE) && reset_n;

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_addr),
        .i_wdata (r_req.wdata),
        .i_raddr (w_addr),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_wait_cnt  <= '0;
            r_rsp_ready <= 1'b0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            r_rsp_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_both) begin
                        // Ambiguous request: flag it and stay put.
                        r_proto_err <= 1'b1;
                    end else if (w_req_rd || w_req_wr) begin
                        r_req.op    <= w_req_wr ? OP_WRITE : OP_READ;
                        r_req.addr  <= bus.mem_addr;
                        r_req.wdata <= bus.mem_wdata;
                        r_wait_cnt  <= WAIT_LOAD;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state     <= ST_RESP;
                        r_rsp_ready <= 1'b1;
                        // Capture read data on entry so it is registered in RESP.
                        if (r_req.op == OP_READ) begin
                            r_rsp_rdata <= w_mem_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (r_req.op == OP_READ) begin
                        r_rd_count <= r_rd_count + 1'b1;
                    end else begin
                        r_wr_count <= r_wr_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_ready = r_rsp_ready;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_proto_err;
    assign bus.rd_count  = r_rd_count;
    assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=4, ADDR_BITS=8).
// Drives the bus interface one step at a time and checks hand-computed results.
module tb_dmem_responder;

    localparam int LAT = 4;
    localparam int AB  = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus_if ();

    dmem_responder #(
        .LATENCY   (LAT),
        .ADDR_BITS (AB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a request until rsp_ready, drop it in the RESP cycle, then step
    // once more so the access has left RESP. lat counts edges from the
    // accepting edge up to the one that raised rsp_ready.
    task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
        bus_if.mem_read  = rd;
        bus_if.mem_write = wr;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        lat   = 0;
        rdata = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (bus_if.rsp_ready === 1'b1) begin
                rdata = bus_if.rsp_rdata;
                break;
            end
        end
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        tick();
    endtask

    initial begin
        int          lat;
        logic [15:0] rdata;
        int          pulses;
        int          busy_low;
        int          first_pulse;
        int          second_pulse;
        int          t;

        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        bus_if.mem_addr  = 16'h0000;
        bus_if.mem_wdata = 16'h0000;

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        check("rst_rsp_ready", 32'(bus_if.rsp_ready), 32'd0);
        check("rst_busy",      32'(bus_if.busy),      32'd0);
        check("rst_proto_err", 32'(bus_if.proto_err), 32'd0);
        check("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'h0);
        check("rst_rd_count",  32'(bus_if.rd_count),  32'd0);
        check("rst_wr_count",  32'(bus_if.wr_count),  32'd0);
        reset_n = 1'b1;
        tick();

        // Write 0x1234 to 0x05: busy right after acceptance, pulse on edge 5
        bus_if.mem_write = 1'b1;
        bus_if.mem_addr  = 16'h0005;
        bus_if.mem_wdata = 16'h1234;
        tick();
        check("wr1_busy_after_accept", 32'(bus_if.busy), 32'd1);
        check("wr1_no_early_ready",    32'(bus_if.rsp_ready), 32'd0);
        bus_if.mem_wdata = 16'hDEAD;   // ignored: request already latched
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (bus_if.rsp_ready === 1'b1) break;
        end
        check("wr1_latency", 32'(lat), 32'(LAT + 1));
        check("wr1_busy_in_resp", 32'(bus_if.busy), 32'd1);
        bus_if.mem_write = 1'b0;
        tick();
        check("wr1_ready_one_cycle", 32'(bus_if.rsp_ready), 32'd0);
        check("wr1_busy_after",      32'(bus_if.busy),      32'd0);
        check("wr1_wr_count",        32'(bus_if.wr_count),  32'd1);

        // Read back 0x05
        access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdata);
        check("rd1_latency",  32'(lat),              32'(LAT + 1));
        check("rd1_rdata",    32'(rdata),            32'h1234);
        check("rd1_rd_count", 32'(bus_if.rd_count),  32'd1);
        check("rd1_hold",     32'(bus_if.rsp_rdata), 32'h1234);

        // Both requests high in IDLE
        bus_if.mem_read  = 1'b1;
        bus_if.mem_write = 1'b1;
        bus_if.mem_addr  = 16'h0005;
        bus_if.mem_wdata = 16'h7777;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.rsp_ready === 1'b1) pulses++;
        end
        bus_if.mem_read  = 1'b0;
        bus_if.mem_write = 1'b0;
        tick();
        check("both_proto_err", 32'(bus_if.proto_err), 32'd1);
        check("both_no_ready",  32'(pulses),           32'd0);
        check("both_busy",      32'(bus_if.busy),      32'd0);
        check("both_rd_count",  32'(bus_if.rd_count),  32'd1);
        check("both_wr_count",  32'(bus_if.wr_count),  32'd1);
        access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdata);
        check("both_mem_untouched", 32'(rdata), 32'h1234);
        check("both_err_sticky", 32'(bus_if.proto_err), 32'd1);

        // Address wrap: 0x0105 aliases 0x05 with 8 address bits
        access(1'b0, 1'b1, 16'h0105, 16'hBEEF, lat, rdata);
        access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdata);
        check("wrap_rd_0005", 32'(rdata), 32'hBEEF);
        access(1'b1, 1'b0, 16'hFF05, 16'h0000, lat, rdata);
        check("wrap_rd_ff05", 32'(rdata), 32'hBEEF);
        check("wrap_rd_count", 32'(bus_if.rd_count), 32'd4);
        check("wrap_wr_count", 32'(bus_if.wr_count), 32'd2);

        // Reset in the 2nd WAIT cycle of a write aborts it
        access(1'b0, 1'b1, 16'h0010, 16'h5555, lat, rdata);
        bus_if.mem_write = 1'b1;
        bus_if.mem_addr  = 16'h0010;
        bus_if.mem_wdata = 16'hAAAA;
        tick();                  // accepting edge -> 1st WAIT cycle
        tick();                  // 2nd WAIT cycle
        check("abort_busy_in_wait", 32'(bus_if.busy), 32'd1);
        reset_n = 1'b0;
        bus_if.mem_write = 1'b0;
        tick();
        reset_n = 1'b1;
        check("abort_busy",      32'(bus_if.busy),      32'd0);
        check("abort_proto_err", 32'(bus_if.proto_err), 32'd0);
        check("abort_rsp_rdata", 32'(bus_if.rsp_rdata), 32'h0);
        check("abort_wr_count",  32'(bus_if.wr_count),  32'd0);
        tick();
        access(1'b1, 1'b0, 16'h0010, 16'h0000, lat, rdata);
        check("abort_prior_value", 32'(rdata), 32'h5555);
        check("abort_wr_count2",   32'(bus_if.wr_count), 32'd0);
        check("abort_rd_count",    32'(bus_if.rd_count), 32'd1);

        // Back-to-back held write requests
        bus_if.mem_write = 1'b1;
        bus_if.mem_addr  = 16'h0020;
        bus_if.mem_wdata = 16'h1111;
        pulses = 0;
        busy_low = 0;
        first_pulse = -1;
        second_pulse = -1;
        t = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            t++;
            if (first_pulse >= 0 && second_pulse < 0 && bus_if.busy === 1'b0) busy_low++;
            if (bus_if.rsp_ready === 1'b1) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse = t;
                    bus_if.mem_addr  = 16'h0021;
                    bus_if.mem_wdata = 16'h2222;
                end else begin
                    second_pulse = t;
                    bus_if.mem_write = 1'b0;
                    break;
                end
            end
        end
        bus_if.mem_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus_if.rsp_ready === 1'b1) pulses++;
        end
        check("b2b_pulse_gap",  32'(second_pulse - first_pulse), 32'(LAT + 2));
        check("b2b_idle_gap",   32'(busy_low),          32'd1);
        check("b2b_pulses",     32'(pulses),            32'd2);
        check("b2b_wr_count",   32'(bus_if.wr_count),   32'd2);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, rdata);
        check("b2b_rd_0020", 32'(rdata), 32'h1111);
        access(1'b1, 1'b0, 16'h0021, 16'h0000, lat, rdata);
        check("b2b_rd_0021", 32'(rdata), 32'h2222);
        check("b2b_rd_count", 32'(bus_if.rd_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
